snake_game_sequencer: RTL and testbench
=======================================

// Module: snake_game_sequencer
// PURPOSE
//   Top-level game-flow controller for the snake datapath. Owns the phase FSM
//   (idle, countdown, play, pause, over) and issues the datapath's restart pulse
//   and movement step tick. Speeds up the step rate as fruit is eaten.
//   Keeps score, level and high score for the VGA overlay.
// PARAMETERS
//   CLK_HZ           100_000_000  clk cycles per countdown second
//   BASE_INTERVAL    100_000_000  step period (cycles) at level 0
//   MIN_INTERVAL      20_000_000  floor on step period
//   INTERVAL_DEC      10_000_000  period reduction per level
//   FRUITS_PER_LEVEL  4           fruits eaten per level-up
//   MAX_LEVEL         15          level saturates here
//   COUNTDOWN_TICKS   3           countdown seconds before play
//   SCORE_W           9           score/high-score width (256 cells fit)
// PORTS
//   clk          in   1        system clock
//   rst          in   1        reset, synchronous, active-high
//   start_btn    in   1        raw start/restart button (asynchronous)
//   pause_btn    in   1        raw pause toggle button (asynchronous)
//   fruit_eaten  in   1        1-cycle pulse from datapath: snake grew
//   collision    in   1        1-cycle pulse from datapath: border/self hit
//   game_reset   out  1        1-cycle pulse: datapath reinitialises snake/fruit
//   step_tick    out  1        1-cycle pulse: datapath advances one cell
//   phase        out  3        PH_IDLE/PH_COUNTDOWN/PH_PLAY/PH_PAUSE/PH_OVER
//   countdown    out  2        seconds remaining, valid in PH_COUNTDOWN
//   score        out  SCORE_W  fruits eaten this game
//   level        out  4        current speed level
//   high_score   out  SCORE_W  best score since rst
// BEHAVIOUR
//   - Reset: phase=IDLE. All outputs 0: game_reset, step_tick, countdown, score,
//     level, high_score. Step counter=0, interval=BASE_INTERVAL. Sync flops=0.
//   - Buttons: 2-flop sync plus rising-edge detect. Press-to-game_reset latency
//     is 3 clk: 2 sync cycles, then 1 registered output cycle. Held buttons
//     repeat nothing.
//   - IDLE/OVER + start -> COUNTDOWN. Same cycle: game_reset=1, score=0, level=0,
//     fruit-in-level=0, countdown=COUNTDOWN_TICKS, second counter=0.
//   - COUNTDOWN: every CLK_HZ cycles, countdown-1. At 0 -> PLAY, step counter=0.
//     Start press here restarts the countdown and pulses game_reset again.
//   - PLAY: step counter increments each cycle. When counter >= interval-1:
//     step_tick=1 for 1 cycle, counter=0. The >= compare means that if a
//     level-up shrinks the interval below the count, the tick fires next cycle.
//   - interval = max(BASE_INTERVAL - level*INTERVAL_DEC, MIN_INTERVAL).
//     Computed in 32-bit unsigned with an underflow guard; registered.
//   - fruit_eaten in PLAY:
//     * score+1, saturating at all-ones.
//     * fruit-in-level+1. On reaching FRUITS_PER_LEVEL: level+1 (saturate at
//       MAX_LEVEL) and fruit-in-level=0.
//   - collision in PLAY -> OVER; step counter frozen.
//     * Next cycle: high_score=score if score>high_score.
//   - pause press in PLAY -> PAUSE; counters hold their values. Pause press in
//     PAUSE -> PLAY and resumes the partial period. Start press in PAUSE ->
//     COUNTDOWN with full restart.
//   - Outside PLAY: fruit_eaten/collision ignored, step_tick held 0.
//   - Simultaneous events:
//     * collision beats fruit_eaten (no score).
//     * collision beats a pending step_tick (tick suppressed).
//     * start beats pause.
//     * rst beats everything, including mid-countdown and mid-pause.
//   - game_reset and step_tick are never high in the same cycle.
// STRUCTURE
//   - snake_pkg: PH_* phase encodings, DIR_* constants, grid dimensions,
//     shared colour constants.
//   - Sub-module btn_sync_edge (sync + rising-edge pulse), instantiated twice.
//   - FSM, second/step counters and score logic are in this module.
// TESTING  (sim params: CLK_HZ=10, BASE=8, MIN=2, DEC=2, FRUITS_PER_LEVEL=2,
//           COUNTDOWN_TICKS=3)
//   1. rst then start press -> game_reset high one cycle 3 clk later.
//      Countdown 3,2,1 every 10 clk, then phase=PLAY.
//   2. PLAY, no events -> step_tick every 8 clk, each exactly 1 cycle wide.
//   3. 4 fruit_eaten pulses -> score=4, level=2, tick period 4.
//      10 more pulses -> level=7, period clamps at 2.
//   4. Pause press 3 clk into a period -> no ticks while paused.
//      Second pause press -> first tick 5 clk after resume.
//   5. collision and fruit_eaten in same cycle, score=5, high_score=3 ->
//      phase=OVER, score stays 5, high_score=5, no further step_tick.
//   6. rst asserted mid-COUNTDOWN and mid-PAUSE -> all outputs match the reset
//      values next cycle, phase=IDLE.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: phase encodings, directions, grid size,
// overlay colours and the step-interval helper used by the sequencer.
package snake_pkg;

    typedef enum logic [2:0] {
        PH_IDLE      = 3'd0,
        PH_COUNTDOWN = 3'd1,
        PH_PLAY      = 3'd2,
        PH_PAUSE     = 3'd3,
        PH_OVER      = 3'd4
    } phase_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_e;

    localparam int unsigned GRID_W = 32'd16;
    localparam int unsigned GRID_H = 32'd16;

    localparam logic [11:0] COLOR_BG     = 12'h000;
    localparam logic [11:0] COLOR_SNAKE  = 12'h0F0;
    localparam logic [11:0] COLOR_FRUIT  = 12'hF00;
    localparam logic [11:0] COLOR_BORDER = 12'hFFF;

    // Step period for a level, floored at min_i; guarded against unsigned wrap.
    function automatic logic [31:0] step_interval(input logic [3:0]  lvl,
                                                  input logic [31:0] base_i,
                                                  input logic [31:0] min_i,
                                                  input logic [31:0] dec_i);
        logic [31:0] dec_total;
        dec_total = {28'd0, lvl} * dec_i;
        if (dec_total >= base_i) begin
            step_interval = min_i;
        end else if ((base_i - dec_total) < min_i) begin
            step_interval = min_i;
        end else begin
            step_interval = base_i - dec_total;
        end
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for a raw button followed by a rising-edge detector;
// emits a single-cycle pulse per press regardless of how long it is held.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchroniser chain plus one-cycle history for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    assign pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/snake_game_sequencer.sv
// Game-flow controller: phase FSM, countdown and step timing, score/level/high
// score tracking, and the restart/step pulses for the snake datapath.
module snake_game_sequencer
    import snake_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 32'd100_000_000,
    parameter int unsigned BASE_INTERVAL    = 32'd100_000_000,
    parameter int unsigned MIN_INTERVAL     = 32'd20_000_000,
    parameter int unsigned INTERVAL_DEC     = 32'd10_000_000,
    parameter int unsigned FRUITS_PER_LEVEL = 32'd4,
    parameter int unsigned MAX_LEVEL        = 32'd15,
    parameter int unsigned COUNTDOWN_TICKS  = 32'd3,
    parameter int unsigned SCORE_W          = 32'd9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic               fruit_eaten,
    input  logic               collision,
    output logic               game_reset,
    output logic               step_tick,
    output logic [2:0]         phase,
    output logic [1:0]         countdown,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         level,
    output logic [SCORE_W-1:0] high_score
);

    localparam logic [31:0]        SEC_LAST   = 32'(CLK_HZ - 32'd1);
    localparam logic [7:0]         FRUIT_LAST = 8'(FRUITS_PER_LEVEL - 32'd1);
    localparam logic [3:0]         LEVEL_MAX  = 4'(MAX_LEVEL);
    localparam logic [1:0]         CD_INIT    = 2'(COUNTDOWN_TICKS);
    localparam logic [SCORE_W-1:0] SCORE_ONE  = {{(SCORE_W-1){1'b0}}, 1'b1};

    phase_e             phase_r, next_phase_s;
    logic               start_p_s, pause_p_s, restart_s, cd_done_s;
    logic [31:0]        sec_cnt_r, sec_cnt_s, step_cnt_r, step_cnt_s, interval_r;
    logic [1:0]         countdown_r, countdown_s;
    logic [SCORE_W-1:0] score_r, score_s, high_score_r, high_score_s;
    logic [3:0]         level_r, level_s;
    logic [7:0]         fruit_cnt_r, fruit_cnt_s;
    logic               game_reset_r, game_reset_s, step_tick_r, step_tick_s;

    btn_sync_edge u_start_sync (.clk(clk), .rst(rst), .btn(start_btn), .pulse(start_p_s));
    btn_sync_edge u_pause_sync (.clk(clk), .rst(rst), .btn(pause_btn), .pulse(pause_p_s));

    // Start restarts the game from every phase except active play.
    assign restart_s = start_p_s && (phase_r != PH_PLAY);
    assign cd_done_s = (sec_cnt_r == SEC_LAST) && (countdown_r == 2'd1);

    // Phase state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_r <= PH_IDLE;
        end else begin
            phase_r <= next_phase_s;
        end
    end

    // Phase transitions; collision outranks pause, start outranks pause.
    always_comb begin
        next_phase_s = phase_r;
        case (phase_r)
            PH_IDLE, PH_OVER: begin
                if (start_p_s) next_phase_s = PH_COUNTDOWN;
                else           next_phase_s = phase_r;
            end
            PH_COUNTDOWN: begin
                if (start_p_s)      next_phase_s = PH_COUNTDOWN;
                else if (cd_done_s) next_phase_s = PH_PLAY;
                else                next_phase_s = phase_r;
            end
            PH_PLAY: begin
                if (collision)      next_phase_s = PH_OVER;
                else if (pause_p_s) next_phase_s = PH_PAUSE;
                else                next_phase_s = phase_r;
            end
            PH_PAUSE: begin
                if (start_p_s)      next_phase_s = PH_COUNTDOWN;
                else if (pause_p_s) next_phase_s = PH_PLAY;
                else                next_phase_s = phase_r;
            end
            default: next_phase_s = PH_IDLE;
        endcase
    end

    // Next values of counters, scoring and the two datapath pulses.
    always_comb begin
        game_reset_s = 1'b0;
        step_tick_s  = 1'b0;
        sec_cnt_s    = sec_cnt_r;
        step_cnt_s   = step_cnt_r;
        countdown_s  = countdown_r;
        score_s      = score_r;
        level_s      = level_r;
        fruit_cnt_s  = fruit_cnt_r;
        if ((phase_r == PH_OVER) && (score_r > high_score_r)) high_score_s = score_r;
        else                                                   high_score_s = high_score_r;
        if (restart_s) begin
            game_reset_s = 1'b1;
            score_s      = '0;
            level_s      = 4'd0;
            fruit_cnt_s  = 8'd0;
            countdown_s  = CD_INIT;
            sec_cnt_s    = 32'd0;
        end else begin
            case (phase_r)
                PH_COUNTDOWN: begin
                    step_cnt_s = 32'd0;
                    if (sec_cnt_r == SEC_LAST) begin
                        sec_cnt_s   = 32'd0;
                        countdown_s = countdown_r - 2'd1;
                    end else begin
                        sec_cnt_s   = sec_cnt_r + 32'd1;
                    end
                end
                PH_PLAY: begin
                    if (collision) begin
                        step_cnt_s = step_cnt_r;
                    end else begin
                        // >= so a shrunken interval fires on the very next cycle
                        if (pause_p_s) begin
                            step_cnt_s = step_cnt_r;
                        end else if (step_cnt_r >= (interval_r - 32'd1)) begin
                            step_tick_s = 1'b1;
                            step_cnt_s  = 32'd0;
                        end else begin
                            step_cnt_s  = step_cnt_r + 32'd1;
                        end
                        if (fruit_eaten) begin
                            if (&score_r) score_s = score_r;
                            else          score_s = score_r + SCORE_ONE;
                            if (fruit_cnt_r == FRUIT_LAST) begin
                                fruit_cnt_s = 8'd0;
                                if (level_r == LEVEL_MAX) level_s = level_r;
                                else                      level_s = level_r + 4'd1;
                            end else begin
                                fruit_cnt_s = fruit_cnt_r + 8'd1;
                            end
                        end else begin
                            score_s = score_r;
                        end
                    end
                end
                default: step_cnt_s = step_cnt_r;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_cnt_r    <= 32'd0;
            step_cnt_r   <= 32'd0;
            interval_r   <= BASE_INTERVAL;
            countdown_r  <= 2'd0;
            score_r      <= '0;
            high_score_r <= '0;
            level_r      <= 4'd0;
            fruit_cnt_r  <= 8'd0;
            game_reset_r <= 1'b0;
            step_tick_r  <= 1'b0;
        end else begin
            sec_cnt_r    <= sec_cnt_s;
            step_cnt_r   <= step_cnt_s;
            interval_r   <= step_interval(level_r, BASE_INTERVAL, MIN_INTERVAL, INTERVAL_DEC);
            countdown_r  <= countdown_s;
            score_r      <= score_s;
            high_score_r <= high_score_s;
            level_r      <= level_s;
            fruit_cnt_r  <= fruit_cnt_s;
            game_reset_r <= game_reset_s;
            step_tick_r  <= step_tick_s;
        end
    end

    assign phase      = phase_r;
    assign countdown  = countdown_r;
    assign score      = score_r;
    assign level      = level_r;
    assign high_score = high_score_r;
    assign game_reset = game_reset_r;
    assign step_tick  = step_tick_r;

endmodule

// File: tb/tb_snake_game_sequencer.sv
// Self-checking bench for snake_game_sequencer: directed scenarios with fixed
// expectations plus a randomized run against a cycle-level reference model.
module tb_snake_game_sequencer;
    import snake_pkg::*;

    localparam int CLK_HZ = 10, BASE = 8, MINI = 2, DEC = 2, FPL = 2, MAXL = 15, CDT = 3, SW = 9;

    logic clk = 1'b0;
    logic rst, start_btn, pause_btn, fruit_eaten, collision;
    logic game_reset, step_tick;
    logic [2:0] phase;
    logic [1:0] countdown;
    logic [SW-1:0] score, high_score;
    logic [3:0] level;

    int n_cmp = 0;
    int n_fail = 0;

    // reference model state
    int m_phase, m_sec, m_cd, m_played, m_interval, m_score, m_level, m_fruit, m_high, m_grst, m_tick;
    bit st_h[3];
    bit pa_h[3];

    snake_game_sequencer #(
        .CLK_HZ(CLK_HZ), .BASE_INTERVAL(BASE), .MIN_INTERVAL(MINI), .INTERVAL_DEC(DEC),
        .FRUITS_PER_LEVEL(FPL), .MAX_LEVEL(MAXL), .COUNTDOWN_TICKS(CDT), .SCORE_W(SW)
    ) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .pause_btn(pause_btn),
        .fruit_eaten(fruit_eaten), .collision(collision), .game_reset(game_reset),
        .step_tick(step_tick), .phase(phase), .countdown(countdown), .score(score),
        .level(level), .high_score(high_score)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase = PH_IDLE; m_sec = 0; m_cd = 0; m_played = 0; m_interval = BASE;
        m_score = 0; m_level = 0; m_fruit = 0; m_high = 0; m_grst = 0; m_tick = 0;
        for (int i = 0; i < 3; i++) begin st_h[i] = 1'b0; pa_h[i] = 1'b0; end
    endtask

    // Advance the model by one clock using the inputs the DUT is about to sample.
    task automatic model_edge();
        bit sp, pp;
        int iv;
        sp = st_h[1] && !st_h[2];
        pp = pa_h[1] && !pa_h[2];
        if (rst) begin
            model_reset();
            return;
        end
        iv = BASE - m_level * DEC;
        if (iv < MINI) iv = MINI;
        m_grst = 0;
        m_tick = 0;
        if (m_phase == PH_OVER && m_score > m_high) m_high = m_score;
        if (sp && m_phase != PH_PLAY) begin
            m_phase = PH_COUNTDOWN; m_grst = 1; m_score = 0; m_level = 0; m_fruit = 0;
            m_cd = CDT; m_sec = 0;
        end else if (m_phase == PH_COUNTDOWN) begin
            m_sec++;
            if (m_sec == CLK_HZ) begin
                m_sec = 0;
                m_cd--;
                if (m_cd == 0) begin m_phase = PH_PLAY; m_played = 0; end
            end
        end else if (m_phase == PH_PLAY) begin
            if (collision) begin
                m_phase = PH_OVER;
            end else begin
                if (pp) begin
                    m_phase = PH_PAUSE;
                end else begin
                    m_played++;
                    if (m_played >= m_interval) begin m_tick = 1; m_played = 0; end
                end
                if (fruit_eaten) begin
                    if (m_score < (1 << SW) - 1) m_score++;
                    m_fruit++;
                    if (m_fruit == FPL) begin
                        m_fruit = 0;
                        if (m_level < MAXL) m_level++;
                    end
                end
            end
        end else if (m_phase == PH_PAUSE && pp) begin
            m_phase = PH_PLAY;
        end
        m_interval = iv;
        st_h[2] = st_h[1]; st_h[1] = st_h[0]; st_h[0] = start_btn;
        pa_h[2] = pa_h[1]; pa_h[1] = pa_h[0]; pa_h[0] = pause_btn;
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_play();
        bit ok;
        ok = 1'b0;
        start_btn = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            cyc();
            if (i == 4) start_btn = 1'b0;
            if (phase == PH_PLAY) ok = 1'b1;
        end
        start_btn = 1'b0;
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL enter_play: phase %0d, wanted PLAY within 60 clk", phase); end
    endtask

    task automatic tick_gap(output int gap);
        int t0;
        gap = -1;
        t0 = -1;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (step_tick === 1'b1) begin
                if (t0 < 0) t0 = i;
                else begin gap = i - t0; break; end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; fruit_eaten = 1'b0; collision = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        n_cmp++;
        if ({game_reset, step_tick, phase, countdown, score, level, high_score} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset: got %h want 0", {game_reset, step_tick, phase, countdown, score, level, high_score});
        end
    endtask

    task automatic test_start();
        logic [2:0] exp_ph;
        logic [1:0] exp_cd;
        start_btn = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            cyc();
            if (i == 5) start_btn = 1'b0;
            exp_ph = (i < 3) ? PH_IDLE : ((i >= 33) ? PH_PLAY : PH_COUNTDOWN);
            exp_cd = (i < 3) ? 2'd0 : 2'(3 - (i - 3) / 10);
            n_cmp++;
            if (game_reset !== (i == 3) || phase !== exp_ph || countdown !== exp_cd) begin
                n_fail++;
                $display("FAIL start clk%0d: got grst=%b ph=%0d cd=%0d want grst=%b ph=%0d cd=%0d",
                         i, game_reset, phase, countdown, (i == 3), exp_ph, exp_cd);
            end
        end
    endtask

    task automatic test_ticks();
        for (int j = 1; j <= 40; j++) begin
            cyc();
            n_cmp++;
            if (step_tick !== (j % 8 == 0) || game_reset !== 1'b0) begin
                n_fail++;
                $display("FAIL tick_period clk%0d: got tick=%b grst=%b want tick=%b grst=0", j, step_tick, game_reset, (j % 8 == 0));
            end
        end
    endtask

    task automatic test_fruit();
        int gap;
        for (int k = 0; k < 4; k++) begin fruit_eaten = 1'b1; cyc(); fruit_eaten = 1'b0; cyc(); end
        n_cmp++;
        if (score !== 9'd4 || level !== 4'd2) begin
            n_fail++; $display("FAIL fruit4: got score=%0d level=%0d want 4/2", score, level);
        end
        tick_gap(gap);
        n_cmp++;
        if (gap !== 4) begin n_fail++; $display("FAIL period_l2: got %0d want 4", gap); end
        for (int k = 0; k < 10; k++) begin fruit_eaten = 1'b1; cyc(); fruit_eaten = 1'b0; cyc(); end
        n_cmp++;
        if (score !== 9'd14 || level !== 4'd7) begin
            n_fail++; $display("FAIL fruit14: got score=%0d level=%0d want 14/7", score, level);
        end
        tick_gap(gap);
        n_cmp++;
        if (gap !== 2) begin n_fail++; $display("FAIL period_clamp: got %0d want 2", gap); end
    endtask

    task automatic test_pause();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cyc();
            if (step_tick === 1'b1) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin n_fail++; $display("FAIL pause_sync: no tick within 20 clk, wanted one"); end
        cyc();
        pause_btn = 1'b1;
        cyc(); cyc(); cyc();
        n_cmp++;
        if (phase !== PH_PAUSE) begin n_fail++; $display("FAIL pause_enter: got phase %0d want %0d", phase, PH_PAUSE); end
        pause_btn = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            n_cmp++;
            if (step_tick !== 1'b0 || phase !== PH_PAUSE) begin
                n_fail++; $display("FAIL paused: got tick=%b phase=%0d want 0/%0d", step_tick, phase, PH_PAUSE);
            end
        end
        pause_btn = 1'b1;
        cyc(); cyc(); cyc();
        n_cmp++;
        if (phase !== PH_PLAY) begin n_fail++; $display("FAIL resume: got phase %0d want %0d", phase, PH_PLAY); end
        pause_btn = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            n_cmp++;
            if (step_tick !== (j == 5)) begin
                n_fail++; $display("FAIL resume_tick clk%0d: got %b want %b", j, step_tick, (j == 5));
            end
        end
    endtask

    task automatic test_over();
        for (int k = 0; k < 3; k++) begin fruit_eaten = 1'b1; cyc(); fruit_eaten = 1'b0; cyc(); end
        collision = 1'b1; cyc(); collision = 1'b0;
        n_cmp++;
        if (phase !== PH_OVER || score !== 9'd3) begin
            n_fail++; $display("FAIL over1: got phase=%0d score=%0d want %0d/3", phase, score, PH_OVER);
        end
        cyc();
        n_cmp++;
        if (high_score !== 9'd3) begin n_fail++; $display("FAIL high1: got %0d want 3", high_score); end
        enter_play();
        n_cmp++;
        if (score !== 9'd0 || level !== 4'd0 || high_score !== 9'd3) begin
            n_fail++; $display("FAIL restart: got score=%0d level=%0d high=%0d want 0/0/3", score, level, high_score);
        end
        for (int k = 0; k < 5; k++) begin fruit_eaten = 1'b1; cyc(); fruit_eaten = 1'b0; cyc(); end
        fruit_eaten = 1'b1; collision = 1'b1; cyc(); fruit_eaten = 1'b0; collision = 1'b0;
        n_cmp++;
        if (phase !== PH_OVER || score !== 9'd5 || high_score !== 9'd3) begin
            n_fail++; $display("FAIL coll_fruit: got phase=%0d score=%0d high=%0d want %0d/5/3", phase, score, high_score, PH_OVER);
        end
        cyc();
        n_cmp++;
        if (high_score !== 9'd5) begin n_fail++; $display("FAIL high2: got %0d want 5", high_score); end
        for (int i = 0; i < 30; i++) begin
            cyc();
            n_cmp++;
            if (step_tick !== 1'b0 || phase !== PH_OVER) begin
                n_fail++; $display("FAIL over_quiet: got tick=%b phase=%0d want 0/%0d", step_tick, phase, PH_OVER);
            end
        end
    endtask

    task automatic test_rst_mid();
        start_btn = 1'b1;
        for (int i = 0; i < 15; i++) cyc();
        start_btn = 1'b0;
        n_cmp++;
        if (phase !== PH_COUNTDOWN) begin n_fail++; $display("FAIL mid_cd: got phase %0d want %0d", phase, PH_COUNTDOWN); end
        rst = 1'b1; cyc(); rst = 1'b0;
        n_cmp++;
        if ({game_reset, step_tick, phase, countdown, score, level, high_score} !== 29'd0) begin
            n_fail++; $display("FAIL rst_cd: got %h want 0", {game_reset, step_tick, phase, countdown, score, level, high_score});
        end
        enter_play();
        for (int k = 0; k < 2; k++) begin fruit_eaten = 1'b1; cyc(); fruit_eaten = 1'b0; cyc(); end
        pause_btn = 1'b1; cyc(); cyc(); cyc(); pause_btn = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
        n_cmp++;
        if (phase !== PH_PAUSE || score !== 9'd2) begin
            n_fail++; $display("FAIL mid_pause: got phase=%0d score=%0d want %0d/2", phase, score, PH_PAUSE);
        end
        rst = 1'b1; cyc(); rst = 1'b0;
        n_cmp++;
        if ({game_reset, step_tick, phase, countdown, score, level, high_score} !== 29'd0) begin
            n_fail++; $display("FAIL rst_pause: got %h want 0", {game_reset, step_tick, phase, countdown, score, level, high_score});
        end
    endtask

    task automatic test_random();
        logic [28:0] got, want;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 59) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 39) == 0) pause_btn = ~pause_btn;
            fruit_eaten = ($urandom_range(0, 7) == 0);
            collision = ($urandom_range(0, 149) == 0);
            cyc();
            got  = {phase, countdown, score, level, high_score, game_reset, step_tick};
            want = {3'(m_phase), 2'(m_cd), 9'(m_score), 4'(m_level), 9'(m_high), 1'(m_grst), 1'(m_tick)};
            n_cmp++;
            if (got !== want) begin
                n_fail++; $display("FAIL random clk%0d: got %h want %h", c, got, want);
            end
        end
        rst = 1'b0; start_btn = 1'b0; pause_btn = 1'b0; fruit_eaten = 1'b0; collision = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; fruit_eaten = 1'b0; collision = 1'b0;
        model_reset();
        test_reset();
        test_start();
        test_ticks();
        test_fruit();
        test_reset();
        enter_play();
        test_pause();
        test_over();
        test_rst_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
